// File: rtl/magnitude_estimator_pipe_if.sv
// rtl/magnitude_estimator_pipe_if.sv - sample-in / magnitude-and-peak-out bundle for magnitude_estimator_pipe
interface magnitude_estimator_pipe_if #(
  parameter int DATA_WIDTH = 82,
  parameter int IDX_WIDTH  = 10
);
  logic                         dataInValid;
  logic signed [DATA_WIDTH-1:0] dataInRe;
  logic signed [DATA_WIDTH-1:0] dataInIm;
  logic [1:0]                   mode;
  logic                         frameStart;
  logic                         dataOutValid;
  logic [DATA_WIDTH:0]          dataOut;
  logic                         peakValid;
  logic [DATA_WIDTH:0]          peakValue;
  logic [IDX_WIDTH-1:0]         peakIndex;

  modport master (
    output dataInValid, dataInRe, dataInIm, mode, frameStart,
    input  dataOutValid, dataOut, peakValid, peakValue, peakIndex
  );

  modport slave (
    input  dataInValid, dataInRe, dataInIm, mode, frameStart,
    output dataOutValid, dataOut, peakValid, peakValue, peakIndex
  );
endinterface

// File: rtl/magnitude_estimator_pipe.sv
// rtl/magnitude_estimator_pipe.sv - 3-stage complex magnitude estimator with per-frame peak tracker
module magnitude_estimator_pipe #(
  parameter int DATA_WIDTH = 82,
  parameter int FRAME_LEN  = 1024,
  parameter int IDX_WIDTH  = $clog2(FRAME_LEN)
) (
  input  logic                       clock,
  input  logic                       resetN,
  magnitude_estimator_pipe_if.slave  bus
);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [0:0] {IDLE, TRACK} state_t;

  // Stage 1: absolute values; 0 - x in DATA_WIDTH bits maps the most negative input to 2^(DATA_WIDTH-1)
  logic [DATA_WIDTH-1:0] abs_re_d, abs_im_d;
  logic [DATA_WIDTH-1:0] s1_abs_re, s1_abs_im;
  logic [1:0]            s1_mode;
  logic                  s1_valid, s1_start;

  assign abs_re_d = bus.dataInRe[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - bus.dataInRe) : bus.dataInRe;
  assign abs_im_d = bus.dataInIm[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - bus.dataInIm) : bus.dataInIm;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_valid  <= 1'b0;
      s1_start  <= 1'b0;
      s1_mode   <= 2'b00;
      s1_abs_re <= '0;
      s1_abs_im <= '0;
    end else begin
      s1_valid  <= bus.dataInValid;
      s1_start  <= bus.dataInValid & bus.frameStart;
      s1_mode   <= bus.mode;
      s1_abs_re <= abs_re_d;
      s1_abs_im <= abs_im_d;
    end
  end

  logic [DATA_WIDTH-1:0] s2_mx, s2_mn;
  logic [1:0]            s2_mode;
  logic                  s2_valid, s2_start;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s2_valid <= 1'b0;
      s2_start <= 1'b0;
      s2_mode  <= 2'b00;
      s2_mx    <= '0;
      s2_mn    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_start <= s1_start;
      s2_mode  <= s1_mode;
      s2_mx    <= (s1_abs_re >= s1_abs_im) ? s1_abs_re : s1_abs_im;
      s2_mn    <= (s1_abs_re >= s1_abs_im) ? s1_abs_im : s1_abs_re;
    end
  end

  logic [DATA_WIDTH:0] mx_w, mn_w, alt_w, mag_d;
  assign mx_w  = {1'b0, s2_mx};
  assign mn_w  = {1'b0, s2_mn};
  assign alt_w = mx_w - (mx_w >> 3) + (mn_w >> 1);

  always_comb begin
    mag_d = '0;
    case (s2_mode)
      2'b00:   mag_d = mx_w + (mn_w >> 2);
      2'b01:   mag_d = mx_w + (mn_w >> 1);
      2'b10:   mag_d = (alt_w > mx_w) ? alt_w : mx_w;
      default: mag_d = mx_w + mn_w;
    endcase
  end

  logic                out_valid, s3_start;
  logic [DATA_WIDTH:0] out_data;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      out_valid <= 1'b0;
      s3_start  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s2_valid;
      s3_start  <= s2_start;
      if (s2_valid) out_data <= mag_d;
    end
  end

  assign bus.dataOutValid = out_valid;
  assign bus.dataOut      = out_data;

  // Peak tracker watches stage-3 outputs and reports one cycle after the frame's last sample
  state_t               state, state_nxt;
  logic [DATA_WIDTH:0]  pk_val, pk_val_nxt, peak_value, peak_value_nxt;
  logic [IDX_WIDTH-1:0] pk_idx, pk_idx_nxt, idx, idx_nxt, peak_index, peak_index_nxt;
  logic                 peak_valid, peak_valid_nxt;
  logic                 better;

  assign better = out_data > pk_val;

  always_comb begin
    state_nxt      = state;
    pk_val_nxt     = pk_val;
    pk_idx_nxt     = pk_idx;
    idx_nxt        = idx;
    peak_valid_nxt = 1'b0;
    peak_value_nxt = peak_value;
    peak_index_nxt = peak_index;
    if (out_valid) begin
      if (s3_start) begin
        pk_val_nxt = out_data;
        pk_idx_nxt = '0;
        idx_nxt    = IDX_WIDTH'(1);
        state_nxt  = TRACK;
      end else if (state == TRACK) begin
        if (better) begin
          pk_val_nxt = out_data;
          pk_idx_nxt = idx;
        end
        if (idx == LAST_IDX) begin
          peak_valid_nxt = 1'b1;
          peak_value_nxt = better ? out_data : pk_val;
          peak_index_nxt = better ? idx : pk_idx;
          state_nxt      = IDLE;
        end else begin
          idx_nxt = idx + IDX_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      pk_val     <= '0;
      pk_idx     <= '0;
      idx        <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_index <= '0;
    end else begin
      state      <= state_nxt;
      pk_val     <= pk_val_nxt;
      pk_idx     <= pk_idx_nxt;
      idx        <= idx_nxt;
      peak_valid <= peak_valid_nxt;
      peak_value <= peak_value_nxt;
      peak_index <= peak_index_nxt;
    end
  end

  assign bus.peakValid = peak_valid;
  assign bus.peakValue = peak_value;
  assign bus.peakIndex = peak_index;
endmodule

// File: tb/tb_magnitude_estimator_pipe.sv
// tb/tb_magnitude_estimator_pipe.sv - scoreboard bench for magnitude_estimator_pipe
module tb_magnitude_estimator_pipe;
  localparam int DW = 16;
  localparam int FL = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic resetN;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int val;
    int idx;
    int cyc;
  } exp_t;

  exp_t out_q[$];
  exp_t pk_q[$];

  magnitude_estimator_pipe_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus();

  magnitude_estimator_pipe #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .IDX_WIDTH(IW)) dut (
    .clock  (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag(input int re, input int im, input int m);
    int a, b, mx, mn, t;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a >= b) ? a : b;
    mn = (a >= b) ? b : a;
    case (m)
      0:       return mx + (mn / 4);
      1:       return mx + (mn / 2);
      2: begin
        t = mx - (mx / 8) + (mn / 2);
        return (t > mx) ? t : mx;
      end
      default: return mx + mn;
    endcase
  endfunction

  task automatic drive(input int re, input int im, input int m, input bit fs);
    exp_t e;
    @(posedge clk);
    #1;
    bus.dataInValid = 1'b1;
    bus.dataInRe    = DW'(re);
    bus.dataInIm    = DW'(im);
    bus.mode        = 2'(m);
    bus.frameStart  = fs;
    e.val = mag(re, im, m);
    e.idx = 0;
    e.cyc = cyc + 3;
    out_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.dataInValid = 1'b0;
      bus.frameStart  = 1'b0;
    end
  endtask

  // Called right after the frame's last sample is driven
  task automatic push_peak(input int v, input int ix);
    exp_t e;
    e.val = v;
    e.idx = ix;
    e.cyc = cyc + 4;
    pk_q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, bus.dataOutValid, 0);
    check({tag, "_out_data"}, bus.dataOut, 0);
    check({tag, "_peak_valid"}, bus.peakValid, 0);
    check({tag, "_peak_value"}, bus.peakValue, 0);
    check({tag, "_peak_index"}, bus.peakIndex, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetN === 1'b1) begin
      if (bus.dataOutValid) begin
        if (out_q.size() == 0) check("out_unexpected", 1, 0);
        else begin
          e = out_q.pop_front();
          check("out_value", bus.dataOut, e.val);
          check("out_latency", cyc, e.cyc);
        end
      end else if (out_q.size() > 0 && out_q[0].cyc < cyc) begin
        e = out_q.pop_front();
        check("out_missing", 0, 1);
      end
      if (bus.peakValid) begin
        if (pk_q.size() == 0) check("peak_unexpected", 1, 0);
        else begin
          e = pk_q.pop_front();
          check("peak_value", bus.peakValue, e.val);
          check("peak_index", bus.peakIndex, e.idx);
          check("peak_cycle", cyc, e.cyc);
        end
      end else if (pk_q.size() > 0 && pk_q[0].cyc < cyc) begin
        e = pk_q.pop_front();
        check("peak_missing", 0, 1);
      end
    end
  end

  initial begin
    int f4[8] = '{5, 9, 3, 9, 2, 1, 0, 4};
    int f5[8] = '{1, 2, 3, 7, 0, 7, 6, 5};
    int f6[8] = '{2, 4, 11, 6, 11, 1, 3, 10};
    logic signed [DW-1:0] rr, ri;

    resetN          = 1'b0;
    bus.dataInValid = 1'b0;
    bus.dataInRe    = '0;
    bus.dataInIm    = '0;
    bus.mode        = 2'b00;
    bus.frameStart  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    resetN = 1'b1;

    drive(-400, 100, 0, 0);
    idle(5);

    drive(300, -200, 1, 0);
    drive(300, -200, 2, 0);
    drive(300, -200, 3, 0);
    idle(5);

    drive(-32768, -32768, 3, 0);
    drive(0, 0, 0, 0);
    idle(5);

    for (int i = 0; i < 24; i++) begin
      rr = DW'($urandom);
      ri = DW'($urandom);
      drive(int'(rr), int'(ri), int'($urandom_range(0, 3)), 0);
    end
    idle(5);

    for (int i = 0; i < 8; i++) drive(f4[i], 0, 0, i == 0);
    push_peak(9, 1);
    idle(5);

    for (int i = 0; i < 8; i++) begin
      if (i == 4) idle(2);
      drive(f4[i], 0, 0, i == 0);
    end
    push_peak(9, 1);
    idle(5);

    for (int i = 0; i < 5; i++) drive(8, 0, 0, i == 0);
    for (int i = 0; i < 8; i++) drive(f5[i], 0, 0, i == 0);
    push_peak(7, 3);
    idle(6);

    for (int i = 0; i < 5; i++) drive(i + 3, 0, 0, i == 0);
    @(posedge clk);
    #1;
    bus.dataInValid = 1'b0;
    bus.frameStart  = 1'b0;
    resetN          = 1'b0;
    out_q.delete();
    pk_q.delete();
    #1;
    check_zero_outputs("midframe_reset");
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_valid", bus.dataOutValid, 0);
    resetN = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) drive(f6[i], 0, 1, i == 0);
    push_peak(11, 2);
    idle(8);

    check("out_q_drained", out_q.size(), 0);
    check("pk_q_drained", pk_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/magnitude_estimator_pipe.md
Name: magnitude_estimator_pipe

Overview:
Pipelined complex-magnitude estimator with run-time selectable approximation mode and per-frame peak tracking. It accepts one signed complex sample per cycle under a valid strobe and produces an unsigned magnitude estimate after a fixed 3-cycle latency. Over each frame of FRAME_LEN output samples it reports the largest magnitude and that sample's index. It sits after the matched-filter output, as a cheaper alternative to square_root_cal, and feeds detection logic.

Parameters:
DATA_WIDTH, 82, width of signed dataInRe/dataInIm.
FRAME_LEN, 1024, output samples per peak-tracking frame; must be at least 2.
IDX_WIDTH, $clog2(FRAME_LEN), width of peakIndex.

Ports:
clock  in  1  rising-edge clock.
resetN  in  1  asynchronous active-low reset.
dataInValid  in  1  qualifies the input sample.
dataInRe  in  DATA_WIDTH  signed real part.
dataInIm  in  DATA_WIDTH  signed imaginary part.
mode  in  2  approximation select; sampled together with the input sample.
frameStart  in  1  marks the input sample as index 0 of a new frame; ignored unless dataInValid is 1.
dataOutValid  out  1  qualifies dataOut.
dataOut  out  DATA_WIDTH+1  unsigned magnitude estimate.
peakValid  out  1  one-cycle pulse when a frame completes.
peakValue  out  DATA_WIDTH+1  largest magnitude in the completed frame.
peakIndex  out  IDX_WIDTH  index of the first occurrence of peakValue.

Behaviour:
- Reset (resetN=0): all outputs and pipeline valid bits go to 0 immediately. Tracker enters IDLE. In-flight samples are discarded and never appear at the output.
- Stage 1 (registered): absRe=|dataInRe| and absIm=|dataInIm| as DATA_WIDTH-bit unsigned values, so -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1). Mode, valid and frameStart are registered alongside.
- Stage 2: mx=max(absRe,absIm), mn=min(absRe,absIm). When the two are equal, mx=absRe.
- Stage 3: dataOut is computed according to mode, with all shifts logical and truncating:
  - 00: mx + (mn>>2)
  - 01: mx + (mn>>1)
  - 10: max(mx, mx - (mx>>3) + (mn>>1))
  - 11: mx + mn
  - Sums are computed at DATA_WIDTH+1 bits; there is no overflow.
- Latency: dataOutValid follows dataInValid by exactly 3 cycles. Throughput is 1 sample/cycle. Bubbles propagate as valid=0.
- While dataOutValid=0, dataOut holds its last valid value.
- Mode travels with each sample, so a mode change between consecutive samples applies per sample with no flush.
- Tracker FSM, acting on stage-3 outputs:
  - IDLE: ignores valid samples until one arrives tagged frameStart. On that sample: peakValue_int=dataOut, peakIndex_int=0, idx=1, go to TRACK.
  - TRACK: on each valid sample, if dataOut > peakValue_int (strictly greater, so ties keep the earlier index), update the value and index to idx. Then increment idx.
  - When the sample at idx=FRAME_LEN-1 is processed, the cycle after that sample's dataOutValid has peakValid=1 and peakValue/peakIndex set to the final result. The FSM then returns to IDLE.
  - A frameStart-tagged sample in TRACK, including at idx=FRAME_LEN-1, aborts the current frame with no peakValid. The tagged sample becomes index 0 of a new frame and the FSM stays in TRACK.
  - peakValue/peakIndex hold between pulses.
  - Gaps (valid=0) inside a frame do not advance idx.
  - Reset mid-frame discards the partial frame; peakValid is not asserted for it.

Test Plan:
1. DATA_WIDTH=16, mode=00, Re=-400, Im=100, single valid -> dataOutValid exactly 3 cycles later, dataOut=425.
2. Back-to-back Re=300, Im=-200 with mode 01,10,11 on consecutive cycles -> three consecutive outputs 400, 363, 500.
3. mode=11, Re=-32768, Im=-32768 -> dataOut=65536 (bit 16 set); mode=00 with Re=0, Im=0 -> 0.
4. FRAME_LEN=8, frameStart on the first sample, Im=0, Re=5,9,3,9,2,1,0,4 (mode 00) -> peakValid one cycle after the 8th output, peakValue=9, peakIndex=1. Repeat with 2 idle cycles inserted mid-frame -> same result, pulse delayed by 2 cycles.
5. frameStart re-asserted on the 6th sample of a frame, then 8 further samples with maximum 7 at position 3 -> no pulse for the aborted frame; one pulse with peakValue=7, peakIndex=3.
6. resetN pulled low while 3 samples are in flight mid-frame -> outputs immediately 0, no dataOutValid or peakValid for those samples. A new frame after release reports correctly.
